// File: rtl/mem_port_arbiter_if.sv
// Shared-memory bus bundle: fetch port, load/store port and the memory port.
// master = pipeline/memory side, slave = the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [31:0]       i_rdata;

   logic              d_req;
   logic              d_we;
   logic [3:0]        d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;

   logic              m_en;
   logic [3:0]        m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_wdata;
   logic [31:0]       m_rdata;

   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-ported word memory,
// routes read data back one cycle later, and freezes traffic on the tohost store.
module mem_port_arbiter #(
   parameter int                ADDR_W          = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR     = 'h0000_5000,
   parameter int                MAX_DATA_STREAK = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus,
   output logic               halt
);
   localparam int                SW          = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0]     STREAK_MAX  = SW'(MAX_DATA_STREAK);
   localparam logic [ADDR_W-1:0] WORD_MASK   = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] TOHOST_WORD = TOHOST_ADDR & WORD_MASK;

   typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

   state_t            state;
   logic [SW-1:0]     streak;
   logic              halt_q;
   logic [31:0]       i_rdata_q;
   logic [31:0]       d_rdata_q;

   logic              open;
   logic              d_win;
   logic              i_gnt;
   logic              d_gnt;
   logic              d_store;
   logic              d_load;
   logic              any_gnt;
   logic [ADDR_W-1:0] word_addr;
   logic              tohost_hit;

   // Data port has priority until it has starved a waiting fetch MAX_DATA_STREAK times.
   assign open    = !rst && !halt_q;
   assign d_win   = bus.d_req && (!bus.i_req || streak != STREAK_MAX);
   assign d_gnt   = open && d_win;
   assign i_gnt   = open && bus.i_req && !d_win;
   assign d_store = d_gnt && bus.d_we;
   assign d_load  = d_gnt && !bus.d_we;
   assign any_gnt = i_gnt || d_gnt;

   assign word_addr  = (d_gnt ? bus.d_addr : bus.i_addr) & WORD_MASK;
   assign tohost_hit = d_store && ((bus.d_addr & WORD_MASK) == TOHOST_WORD) &&
                       bus.d_be[0] && (bus.d_wdata[7:0] == 8'h01);

   assign bus.i_gnt   = i_gnt;
   assign bus.d_gnt   = d_gnt;
   assign bus.m_en    = any_gnt;
   assign bus.m_we    = d_store ? bus.d_be : 4'b0000;
   assign bus.m_addr  = any_gnt ? word_addr : '0;
   assign bus.m_wdata = d_store ? bus.d_wdata : 32'h0;

   // Reset masks the response path immediately so a pending response is dropped.
   assign bus.i_rvalid = !rst && (state == RESP_I);
   assign bus.d_rvalid = !rst && (state == RESP_D);
   assign bus.i_rdata  = rst ? 32'h0 : ((state == RESP_I) ? bus.m_rdata : i_rdata_q);
   assign bus.d_rdata  = rst ? 32'h0 : ((state == RESP_D) ? bus.m_rdata : d_rdata_q);
   assign halt         = !rst && halt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         i_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
      end else begin
         if (i_gnt)       state <= RESP_I;
         else if (d_load) state <= RESP_D;
         else             state <= IDLE;
         if (state == RESP_I) i_rdata_q <= bus.m_rdata;
         if (state == RESP_D) d_rdata_q <= bus.m_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
         halt_q <= 1'b0;
      end else begin
         if (i_gnt || !bus.i_req)
            streak <= '0;
         else if (d_gnt && streak != STREAK_MAX)
            streak <= streak + 1'b1;
         if (tohost_hit)
            halt_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter with a behavioural word memory.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;
   logic halt0;
   logic halt1;

   mem_port_arbiter_if #(.ADDR_W(32)) b0 ();
   mem_port_arbiter_if #(.ADDR_W(32)) b1 ();

   mem_port_arbiter #(.ADDR_W(32), .TOHOST_ADDR(32'h0000_5000), .MAX_DATA_STREAK(4)) dut0 (
      .clk(clk), .rst(rst), .bus(b0), .halt(halt0));
   mem_port_arbiter #(.ADDR_W(32), .TOHOST_ADDR(32'h0000_5000), .MAX_DATA_STREAK(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1), .halt(halt1));

   assign b1.i_req   = b0.i_req;
   assign b1.i_addr  = b0.i_addr;
   assign b1.d_req   = b0.d_req;
   assign b1.d_we    = b0.d_we;
   assign b1.d_be    = b0.d_be;
   assign b1.d_addr  = b0.d_addr;
   assign b1.d_wdata = b0.d_wdata;
   assign b1.m_rdata = 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: word k preloaded with 0xA000_0000 + k.
   logic [31:0] mem [0:8191];
   logic [31:0] mrd;
   assign b0.m_rdata = mrd;
   initial begin
      for (int k = 0; k < 8192; k++) mem[k] = 32'hA000_0000 + k;
      mrd = 32'h0;
   end
   always @(posedge clk) begin
      if (b0.m_en) begin
         for (int j = 0; j < 4; j++)
            if (b0.m_we[j]) mem[b0.m_addr[14:2]][8*j +: 8] <= b0.m_wdata[8*j +: 8];
         if (b0.m_we == 4'b0000) mrd <= mem[b0.m_addr[14:2]];
      end
   end

   typedef struct packed {
      logic        ig, dg, me;
      logic [3:0]  mwe;
      logic [31:0] ma, mwd;
      logic        irv;
      logic [31:0] ird;
      logic        drv;
      logic [31:0] drd;
      logic        h;
   } out_t;

   typedef struct packed {
      logic        rst, ir;
      logic [31:0] ia;
      logic        dr, dw;
      logic [3:0]  dbe;
      logic [31:0] da, dwd;
      out_t        exp;
   } vec_t;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam int NV = 25;

   out_t act0;
   assign act0 = {b0.i_gnt, b0.d_gnt, b0.m_en, b0.m_we, b0.m_addr, b0.m_wdata,
                  b0.i_rvalid, b0.i_rdata, b0.d_rvalid, b0.d_rdata, halt0};

   int n_chk;
   int n_fail;

   task automatic chk_vec(input int idx, input out_t a, input out_t e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL vec%0d: got ig=%b dg=%b me=%b we=%h ma=%h wd=%h irv=%b ird=%h drv=%b drd=%h halt=%b, expected ig=%b dg=%b me=%b we=%h ma=%h wd=%h irv=%b ird=%h drv=%b drd=%h halt=%b",
                  idx, a.ig, a.dg, a.me, a.mwe, a.ma, a.mwd, a.irv, a.ird, a.drv, a.drd, a.h,
                  e.ig, e.dg, e.me, e.mwe, e.ma, e.mwd, e.irv, e.ird, e.drv, e.drd, e.h);
      end
   endtask

   task automatic chk_bits(input string nm, input int idx, input logic [95:0] a, input logic [95:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, a, e);
      end
   endtask

   vec_t v [NV];
   logic ei, ei1, pi, pd;

   initial begin
      n_chk = 0;
      n_fail = 0;
      //          rst ir  ia          dr dw dbe    da           dwd            ig dg me we     ma           mwd           irv ird           drv drd           halt
      v[0]  = '{H, H, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'h0,        L}};
      v[1]  = '{L, H, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{H, L, H, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'h0,        L}};
      v[2]  = '{L, H, 32'h4,  L, L, 4'h0, 32'h0,   32'h0,       '{H, L, H, 4'h0, 32'h4,   32'h0,       H, 32'hA0000000, L, 32'h0,        L}};
      v[3]  = '{L, H, 32'hA,  L, L, 4'h0, 32'h0,   32'h0,       '{H, L, H, 4'h0, 32'h8,   32'h0,       H, 32'hA0000001, L, 32'h0,        L}};
      v[4]  = '{L, L, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       H, 32'hA0000002, L, 32'h0,        L}};
      v[5]  = '{L, L, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'hA0000002, L, 32'h0,        L}};
      v[6]  = '{L, L, 32'h0,  H, H, 4'h4, 32'h103, 32'h00AB0000,'{L, H, H, 4'h4, 32'h100, 32'h00AB0000,L, 32'hA0000002, L, 32'h0,        L}};
      v[7]  = '{L, L, 32'h0,  H, L, 4'hF, 32'h100, 32'h12345678,'{L, H, H, 4'h0, 32'h100, 32'h0,       L, 32'hA0000002, L, 32'h0,        L}};
      v[8]  = '{L, L, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'hA0000002, H, 32'hA0AB0040, L}};
      v[9]  = '{L, H, 32'hC,  H, L, 4'h0, 32'h4,   32'h0,       '{L, H, H, 4'h0, 32'h4,   32'h0,       L, 32'hA0000002, L, 32'hA0AB0040, L}};
      v[10] = '{L, H, 32'hC,  L, L, 4'h0, 32'h0,   32'h0,       '{H, L, H, 4'h0, 32'hC,   32'h0,       L, 32'hA0000002, H, 32'hA0000001, L}};
      v[11] = '{L, L, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       H, 32'hA0000003, L, 32'hA0000001, L}};
      v[12] = '{L, L, 32'h0,  H, L, 4'h0, 32'h8,   32'h0,       '{L, H, H, 4'h0, 32'h8,   32'h0,       L, 32'hA0000003, L, 32'hA0000001, L}};
      v[13] = '{H, L, 32'h0,  H, L, 4'h0, 32'h8,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'h0,        L}};
      v[14] = '{L, L, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'h0,        L}};
      v[15] = '{L, L, 32'h0,  H, L, 4'h0, 32'hC,   32'h0,       '{L, H, H, 4'h0, 32'hC,   32'h0,       L, 32'h0,        L, 32'h0,        L}};
      v[16] = '{L, L, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'h0,        H, 32'hA0000003, L}};
      v[17] = '{L, L, 32'h0,  H, H, 4'h1, 32'h5000,32'h2,       '{L, H, H, 4'h1, 32'h5000,32'h2,       L, 32'h0,        L, 32'hA0000003, L}};
      v[18] = '{L, L, 32'h0,  H, L, 4'h0, 32'h0,   32'h0,       '{L, H, H, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'hA0000003, L}};
      v[19] = '{L, H, 32'h10, H, H, 4'h1, 32'h5000,32'h1,       '{L, H, H, 4'h1, 32'h5000,32'h1,       L, 32'h0,        H, 32'hA0000000, L}};
      v[20] = '{L, H, 32'h10, H, L, 4'h0, 32'h4,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'hA0000000, H}};
      v[21] = '{L, H, 32'h10, H, L, 4'h0, 32'h4,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'hA0000000, H}};
      v[22] = '{H, H, 32'h10, H, L, 4'h0, 32'h4,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       L, 32'h0,        L, 32'h0,        L}};
      v[23] = '{L, H, 32'h10, L, L, 4'h0, 32'h0,   32'h0,       '{H, L, H, 4'h0, 32'h10,  32'h0,       L, 32'h0,        L, 32'h0,        L}};
      v[24] = '{L, L, 32'h0,  L, L, 4'h0, 32'h0,   32'h0,       '{L, L, L, 4'h0, 32'h0,   32'h0,       H, 32'hA0000004, L, 32'h0,        L}};

      #1;
      for (int k = 0; k < NV; k++) begin
         rst = v[k].rst;
         b0.i_req = v[k].ir;  b0.i_addr = v[k].ia;
         b0.d_req = v[k].dr;  b0.d_we = v[k].dw;  b0.d_be = v[k].dbe;
         b0.d_addr = v[k].da; b0.d_wdata = v[k].dwd;
         #2;
         chk_vec(k, act0, v[k].exp);
         @(posedge clk); #1;
      end

      // Both requesters held: DDDDI repeating (streak 4) and D,I alternation (streak 1).
      pi = 1'b0;
      pd = 1'b0;
      for (int c = 0; c < 10; c++) begin
         rst = 1'b0;
         b0.i_req = 1'b1; b0.i_addr = 32'h20;
         b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_be = 4'hF; b0.d_addr = 32'h4; b0.d_wdata = 32'h0;
         #2;
         ei  = (c % 5 == 4);
         ei1 = (c % 2 == 1);
         chk_bits("contend_arb", c, {94'h0, b0.i_gnt, b0.d_gnt}, {94'h0, ei, !ei});
         chk_bits("contend_alt", c, {93'h0, b1.i_gnt, b1.d_gnt, halt1}, {93'h0, ei1, !ei1, 1'b0});
         chk_bits("contend_resp", c,
                  {30'h0, b0.i_rvalid, pi ? b0.i_rdata : 32'h0, b0.d_rvalid, pd ? b0.d_rdata : 32'h0},
                  {30'h0, pi, pi ? 32'hA0000008 : 32'h0, pd, pd ? 32'hA0000001 : 32'h0});
         pi = ei;
         pd = !ei;
         @(posedge clk); #1;
      end
      b0.i_req = 1'b0;
      b0.d_req = 1'b0;
      #2;
      chk_bits("contend_tail", 0, {30'h0, b0.i_rvalid, b0.i_rdata, b0.d_rvalid, 32'h0},
               {30'h0, 1'b1, 32'hA0000008, 1'b0, 32'h0});
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
